// File: rtl/instr_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_sequencer : program store plus fetch/issue controller that feeds a
//                   processor DIN bus one instruction at a time.
// Revision 1.0
// ----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int         DATA_W  = 16,
    parameter int         ADDR_W  = 5,
    parameter logic [2:0] MVI_OP  = 3'b001,
    parameter int         TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              done,
    output logic [DATA_W-1:0] din,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_IMM   = 3'd3,
        S_WAIT  = 3'd4,
        S_HALT  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    // One extra bit so an immediate fetched past DEPTH-1 still trips the halt check
    logic [ADDR_W:0]   pc_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   pc_inc_d;
    logic [WD_W-1:0]   wd_q;
    logic [DATA_W-1:0] din_q;
    logic              run_q;
    logic              busy_q;
    logic              halted_q;
    logic              err_q;
    logic              start_ok_d;

    assign pc_inc_d   = pc_q + {{ADDR_W{1'b0}}, 1'b1};
    assign start_ok_d = start & ~load_en & ~busy_q;

    always_ff @(posedge clock) begin
        if (load_en && !busy_q) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            wd_q     <= '0;
            din_q    <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            run_q <= 1'b0;
            case (state_q)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (start_ok_d) begin
                        len_q    <= prog_len;
                        pc_q     <= '0;
                        wd_q     <= '0;
                        err_q    <= 1'b0;
                        halted_q <= 1'b0;
                        if (prog_len == '0) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    din_q   <= mem_q[pc_q[ADDR_W-1:0]];
                    run_q   <= 1'b1;
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    wd_q <= '0;
                    if (din_q[8:6] == MVI_OP) begin
                        state_q <= S_IMM;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_IMM: begin
                    pc_q    <= pc_inc_d;
                    din_q   <= mem_q[pc_inc_d[ADDR_W-1:0]];
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (done) begin
                        wd_q <= '0;
                        if (pc_inc_d >= len_q) begin
                            pc_q     <= {1'b0, pc_inc_d[ADDR_W-1:0]};
                            state_q  <= S_HALT;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q    <= pc_inc_d;
                            state_q <= S_FETCH;
                        end
                    end else if (wd_q == WD_LAST) begin
                        wd_q    <= '0;
                        state_q <= S_ERROR;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign din    = din_q;
    assign run    = run_q;
    assign pc     = pc_q[ADDR_W-1:0];
    assign busy   = busy_q;
    assign halted = halted_q;
    assign err    = err_q;

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program store plus fetch/issue controller that sits directly upstream of the processor.
- Holds a small instruction program and drives the processor's 16-bit DIN bus and run strobe one instruction at a time.
- Waits for the processor's done pulse before issuing the next instruction.
- Handles two-word (mvi) instructions by presenting the immediate word in the cycle after issue; provides a done watchdog and halt/error status for the bench.

Parameters:
- DATA_W, 16, instruction/data word width (matches processor DIN).
- ADDR_W, 5, program memory address width; DEPTH = 2**ADDR_W words.
- MVI_OP, 3'b001, opcode value in word bits [8:6] marking a two-word instruction.
- TIMEOUT, 16, max cycles in WAIT without done before entering ERROR (must be >= 2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  write program word this cycle (ignored while busy=1).
- load_addr  in  ADDR_W  program write address.
- load_data  in  DATA_W  program write data.
- prog_len  in  ADDR_W+1  number of valid program words (0..DEPTH); sampled on start.
- start  in  1  begin execution from address 0 (ignored while busy=1).
- done  in  1  processor instruction-complete pulse.
- din  out  DATA_W  word presented to processor DIN, registered.
- run  out  1  one-cycle issue strobe to processor.
- pc  out  ADDR_W  address of current instruction word.
- busy  out  1  high in FETCH/ISSUE/IMM/WAIT.
- halted  out  1  program finished normally.
- err  out  1  watchdog expired.

Behaviour:
- Reset (async, any state, mid-operation included): state=IDLE; din=0, run=0, pc=0, busy=0, halted=0, err=0; watchdog=0; len_q=0. Memory contents are not reset.
- Memory: synchronous write on load_en when busy=0. Read is combinational; din is registered from it.
- Simultaneous load_en and start while not busy: the write is performed, start is ignored.
- start while not busy, in IDLE/HALT/ERROR:
  - len_q<=prog_len; pc<=0; halted<=0; err<=0.
  - If prog_len==0: go to HALT (halted=1) next cycle, no run pulse.
  - Otherwise go to FETCH.
- FETCH (1 cycle): din<=mem[pc]; next state ISSUE.
- ISSUE (1 cycle): run=1, din stable.
  - If din[8:6]==MVI_OP: next state IMM.
  - Otherwise: next state WAIT.
  - Issue latency: run rises 2 cycles after the cycle in which start was sampled.
- IMM (1 cycle): pc<=pc+1 (mod DEPTH); din<=mem[pc+1]; next state WAIT. The immediate is on din during the processor's step after run.
- WAIT: run=0; din holds; watchdog increments each cycle.
  - done=1: watchdog<=0; pc_next=pc+1 using an ADDR_W+1 bit compare.
    - pc_next>=len_q: go to HALT (pc<=pc_next truncated).
    - Otherwise pc<=pc_next and go to FETCH.
  - Watchdog reaches TIMEOUT-1 with no done: go to ERROR, err=1. done in that same cycle wins over the timeout.
- done outside WAIT is ignored; it is neither counted nor latched.
- HALT: halted=1, busy=0, run=0; din holds its last value.
- ERROR: err=1, busy=0, run=0. Left only via start or reset.
- An mvi at the last valid address reads its immediate from pc+1 even if that is ≥len_q or wraps past DEPTH-1 to 0. The halt check then follows normally.
- run is never asserted in two consecutive cycles, and only once per instruction.

Test Plan:
- Reset mid-WAIT (pc=3) -> next edge state IDLE, pc=0, busy=0, run=0, din=0; memory contents unchanged (re-run reproduces the same program).
- Load mem[0]=16'h0040 (op 001 = mvi), mem[1]=16'h0005, mem[2]=16'h0008; prog_len=3; start; done 3 cycles after each run:
  - run pulse with din=0040, then din=0005 with pc=1.
  - Then run with din=0008, pc=2.
  - Then halted=1, busy=0, exactly 2 run pulses total.
- prog_len=0, start -> halted=1 next cycle, no run pulse, pc=0.
- Never assert done after the first run with TIMEOUT=16 -> err=1 exactly 16 cycles after entering WAIT; start then clears err and restarts at pc=0.
- load_en asserted while busy (addr 2, data FFFF) -> mem[2] unchanged, verified on the next run. load_en together with start in IDLE -> the write occurs, busy stays 0.
- mvi at address DEPTH-1 with prog_len=32 -> immediate taken from mem[0] (wrap); after done, halted=1.
